// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the 71V016SA access sequencer.
// Holds the sequencer state encoding, the default strobe timing, the width of
// the duration timer and a helper that turns a cycle count into a timer load.
package sram_pkg;

    // Duration timer width; every programmable duration is 1..15 cycles
    localparam int TMR_W = 4;

    // Default timing at 100 MHz: 20 ns OE, 20 ns WE, 10 ns bus turnaround
    localparam int DEF_RD_WAIT  = 2;
    localparam int DEF_WR_PULSE = 2;
    localparam int DEF_TURN_CYC = 1;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_RD_ACT  = 3'd2,
        ST_WR_ACT  = 3'd3,
        ST_WR_HOLD = 3'd4,
        ST_TURN    = 3'd5
    } state_t;

    // The timer counts down to zero and flags done on zero, so a state that
    // must last N cycles loads N-1 on entry.
    function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_seq_timer.sv
// sram_seq_timer: loadable down-counter that times the read-active,
// write-active and turnaround phases. done is high while the count is zero;
// the count parks at zero until the next load.
module sram_seq_timer
    import sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_bar,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_reg;

    // Load on phase entry, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - TMR_W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/sram_seq.sv
// sram_seq: registered single-word access sequencer for the 71V016SA SRAM.
// Turns read/write requests into CS/OE/WE strobes, address and data-bus
// enable. Every pin-facing output is a flop: the next-state logic computes the
// value each pin must carry in the following cycle and registers it.
// Optional feature: define SRAM_SEQ_WRITE_LOCK_EN to add wr_enable/wr_err.
// A write accepted while wr_enable is low walks the full write sequence with
// WE and the data-bus enable suppressed, and sets the sticky wr_err flag.
module sram_seq
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              cs_bar,
    output logic              oe_bar,
    output logic              we_bar
`ifdef SRAM_SEQ_WRITE_LOCK_EN
    ,
    input  logic              wr_enable,
    output logic              wr_err
`endif
);

    // Timer load values for each timed phase
    localparam logic [TMR_W-1:0] RD_LOAD   = tmr_load(RD_WAIT);
    localparam logic [TMR_W-1:0] WR_LOAD   = tmr_load(WR_PULSE);
    localparam logic [TMR_W-1:0] TURN_LOAD = tmr_load(TURN_CYC);

    state_t             state_reg, state_next;
    logic               ready_reg, ready_next;
    logic               cs_reg, cs_next;
    logic               oe_reg, oe_next;
    logic               we_reg, we_next;
    logic               dq_oe_reg, dq_oe_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  dq_out_reg, dq_out_next;
    logic               write_reg, write_next;
    logic               rd_valid_reg;
    logic [DATA_W-1:0]  rd_data_reg;

    logic               rd_capture;
    logic               tmr_load_en;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_done;

    // lock_accept: the request being accepted now is a locked write.
    // lock_reg:    the access in flight is a locked write.
    logic               lock_accept;
    logic               lock_reg;

`ifdef SRAM_SEQ_WRITE_LOCK_EN
    logic               wr_err_reg;
    logic               accept_now;

    assign accept_now  = (state_reg == ST_IDLE) && req_valid && ready_reg;
    assign lock_accept = req_write && !wr_enable;

    // Latch the lock decision per access; the error flag is sticky until reset
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            lock_reg   <= 1'b0;
            wr_err_reg <= 1'b0;
        end else if (accept_now) begin
            lock_reg <= lock_accept;
            if (lock_accept) begin
                wr_err_reg <= 1'b1;
            end
        end
    end

    assign wr_err = wr_err_reg;
`else
    assign lock_accept = 1'b0;
    assign lock_reg    = 1'b0;
`endif

    sram_seq_timer u_timer (
        .clk      (clk),
        .rst_bar  (rst_bar),
        .load     (tmr_load_en),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Next state and the pin values for the following cycle
    always_comb begin
        state_next   = state_reg;
        ready_next   = 1'b0;
        cs_next      = 1'b1;
        oe_next      = 1'b1;
        we_next      = 1'b1;
        dq_oe_next   = 1'b0;
        addr_next    = addr_reg;
        dq_out_next  = dq_out_reg;
        write_next   = write_reg;
        tmr_load_en  = 1'b0;
        tmr_load_val = '0;
        rd_capture   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready_next = 1'b1;
                if (req_valid && ready_reg) begin
                    ready_next = 1'b0;
                    state_next = ST_SETUP;
                    cs_next    = 1'b0;
                    addr_next  = req_addr;
                    write_next = req_write;
                    if (req_write) begin
                        dq_out_next = req_wdata;
                        dq_oe_next  = !lock_accept;
                    end
                end
            end

            ST_SETUP: begin
                cs_next     = 1'b0;
                tmr_load_en = 1'b1;
                if (write_reg) begin
                    state_next   = ST_WR_ACT;
                    tmr_load_val = WR_LOAD;
                    we_next      = lock_reg;
                    dq_oe_next   = !lock_reg;
                end else begin
                    state_next   = ST_RD_ACT;
                    tmr_load_val = RD_LOAD;
                    oe_next      = 1'b0;
                end
            end

            ST_RD_ACT: begin
                if (tmr_done) begin
                    // Data has been valid for the whole OE window; capture it
                    // while OE is still low, then release the bus.
                    rd_capture   = 1'b1;
                    state_next   = ST_TURN;
                    tmr_load_en  = 1'b1;
                    tmr_load_val = TURN_LOAD;
                end else begin
                    cs_next = 1'b0;
                    oe_next = 1'b0;
                end
            end

            ST_WR_ACT: begin
                // CS and data stay on through WR_HOLD so WE rises first
                cs_next    = 1'b0;
                dq_oe_next = !lock_reg;
                if (tmr_done) begin
                    state_next = ST_WR_HOLD;
                end else begin
                    we_next = lock_reg;
                end
            end

            ST_WR_HOLD: begin
                state_next   = ST_TURN;
                tmr_load_en  = 1'b1;
                tmr_load_val = TURN_LOAD;
            end

            ST_TURN: begin
                if (tmr_done) begin
                    state_next = ST_IDLE;
                    ready_next = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // Control state and strobes; reset forces strobes high without a clock
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            cs_reg    <= 1'b1;
            oe_reg    <= 1'b1;
            we_reg    <= 1'b1;
            dq_oe_reg <= 1'b0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            cs_reg    <= cs_next;
            oe_reg    <= oe_next;
            we_reg    <= we_next;
            dq_oe_reg <= dq_oe_next;
            write_reg <= write_next;
        end
    end

    // Address, write data and read capture registers
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            addr_reg     <= '0;
            dq_out_reg   <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            addr_reg     <= addr_next;
            dq_out_reg   <= dq_out_next;
            rd_valid_reg <= rd_capture;
            if (rd_capture) begin
                rd_data_reg <= sram_dq_in;
            end
        end
    end

    assign req_ready   = ready_reg;
    assign cs_bar      = cs_reg;
    assign oe_bar      = oe_reg;
    assign we_bar      = we_reg;
    assign sram_dq_oe  = dq_oe_reg;
    assign sram_addr   = addr_reg;
    assign sram_dq_out = dq_out_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_sram_seq.sv
// tb_sram_seq: directed and random accesses against a behavioural SRAM array
// and a word-level reference memory; per-cycle strobe waveform derived from
// the access timing rules. Define SRAM_SEQ_WRITE_LOCK_EN to include the
// write-lock section.
module tb_sram_seq;

    localparam int RD_WAIT  = 2;
    localparam int WR_PULSE = 2;
    localparam int TURN_CYC = 1;
    localparam logic [5:0] IDLE_V = 6'b111001; // cs,oe,we,dq_oe,rd_valid,ready

    logic        clk = 1'b0;
    logic        rst_bar;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        cs_bar, oe_bar, we_bar;
`ifdef SRAM_SEQ_WRITE_LOCK_EN
    logic        wr_enable;
    logic        wr_err;
    logic        err_exp;
`endif

    sram_seq #(
        .ADDR_W(16), .DATA_W(16),
        .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk         (clk),
        .rst_bar     (rst_bar),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .cs_bar      (cs_bar),
        .oe_bar      (oe_bar),
        .we_bar      (we_bar)
`ifdef SRAM_SEQ_WRITE_LOCK_EN
        ,
        .wr_enable   (wr_enable),
        .wr_err      (wr_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: drives stored word while selected with OE low
    logic [15:0] sram_mem [0:65535];
    assign sram_dq_in = (!cs_bar && !oe_bar) ? sram_mem[sram_addr] : 16'hDEAD;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    logic [15:0] ref_mem [int];

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
    } txn_t;
    txn_t burst_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 7) ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] ref_read(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic add(input bit wr, input logic [15:0] a, input logic [15:0] d);
        txn_t x;
        x.wr = wr;
        x.a  = a;
        x.d  = d;
        burst_q.push_back(x);
    endtask

    task automatic drive(input txn_t x);
        req_valid = 1'b1;
        req_write = x.wr;
        req_addr  = x.a;
        req_wdata = x.d;
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(tag, 32'({cs_bar, oe_bar, we_bar, sram_dq_oe, rd_valid, req_ready}), 32'(IDLE_V));
        end
    endtask

    // Runs burst_q with req_valid held high between accesses; must be entered
    // at a falling edge while the sequencer is idle.
    task automatic run_burst();
        for (int t = 0; t < burst_q.size(); t++) begin
            txn_t        x;
            bit          locked;
            int          n_exp, act_end, k;
            logic [5:0]  exp_v;
            logic [15:0] rd_exp;
            x      = burst_q[t];
            locked = 1'b0;
`ifdef SRAM_SEQ_WRITE_LOCK_EN
            locked = x.wr && !wr_enable;
            if (locked) err_exp = 1'b1;
`endif
            if (t == 0) drive(x);
            n_exp   = x.wr ? WR_PULSE + 3 + TURN_CYC : RD_WAIT + 2 + TURN_CYC;
            act_end = x.wr ? WR_PULSE + 2 : RD_WAIT + 1;
            rd_exp  = ref_read(int'(x.a));
            @(posedge clk);
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) begin
                    if (t + 1 < burst_q.size()) drive(burst_q[t + 1]);
                    else req_valid = 1'b0;
                end
                exp_v[5] = !(k <= act_end);
                exp_v[4] = !(!x.wr && k >= 2 && k <= RD_WAIT + 1);
                exp_v[3] = !(x.wr && !locked && k >= 2 && k <= WR_PULSE + 1);
                exp_v[2] = x.wr && !locked && k <= WR_PULSE + 2;
                exp_v[1] = !x.wr && k == RD_WAIT + 2;
                exp_v[0] = (k == n_exp);
                chk($sformatf("strobes txn%0d k=%0d", n_txn, k),
                    32'({cs_bar, oe_bar, we_bar, sram_dq_oe, rd_valid, req_ready}), 32'(exp_v));
                chk("oe_dqoe_overlap", 32'(!oe_bar && sram_dq_oe), 32'(0));
                chk("oe_we_both_low", 32'(!oe_bar && !we_bar), 32'(0));
                chk("sram_addr", 32'(sram_addr), 32'(x.a));
                if (exp_v[2]) chk("dq_out", 32'(sram_dq_out), 32'(x.d));
                if (exp_v[1]) chk("rd_data", 32'(rd_data), 32'(rd_exp));
`ifdef SRAM_SEQ_WRITE_LOCK_EN
                chk("wr_err", 32'(wr_err), 32'(err_exp));
`endif
                if (!cs_bar && !we_bar && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
            end while (!req_ready && k < 40);
            chk("spacing", 32'(k), 32'(n_exp));
            if (x.wr && !locked) ref_mem[int'(x.a)] = x.d;
            $display("txn %0d %s addr=%04h data=%04h cycles=%0d%s", n_txn,
                     x.wr ? "WR" : "RD", x.a, x.wr ? x.d : rd_exp, k, locked ? " locked" : "");
            n_txn++;
        end
        burst_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram_mem[i] = init_word(i);
        rst_bar   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef SRAM_SEQ_WRITE_LOCK_EN
        wr_enable = 1'b1;
        err_exp   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", 32'({cs_bar, oe_bar, we_bar, sram_dq_oe, rd_valid, req_ready}), 32'(IDLE_V));
        rst_bar = 1'b1;

        // Reset values, then ten idle cycles
        chk("reset_addr", 32'(sram_addr), 32'(0));
        chk("reset_dq_out", 32'(sram_dq_out), 32'(0));
        chk("reset_rd_data", 32'(rd_data), 32'(0));
        idle_check(10, "idle_after_reset");

        // Directed write then read back
        add(1'b1, 16'h1234, 16'hA5C3);
        run_burst();
        add(1'b0, 16'h1234, 16'h0000);
        run_burst();

        // Back-to-back read, write, read
        add(1'b0, 16'h1234, 16'h0000);
        add(1'b1, 16'h0007, 16'h5A3C);
        add(1'b0, 16'h0007, 16'h0000);
        run_burst();

        // Random bursts over a small address window to force reuse
        repeat (10) begin
            int len;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++)
                add(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
            run_burst();
            idle_check($urandom_range(0, 3), "idle_between");
        end

        // Reset during the write pulse: strobes release without a clock edge
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'hFFFF;
        req_wdata = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("we_low_before_reset", 32'(we_bar), 32'(0));
        #2 rst_bar = 1'b0;
        #1;
        chk("async_reset_strobes", 32'({cs_bar, oe_bar, we_bar, sram_dq_oe}), 32'(4'b1110));
        @(posedge clk);
        @(negedge clk);
        rst_bar = 1'b1;
        chk("post_reset_rd_data", 32'(rd_data), 32'(0));
        idle_check(5, "idle_after_abort");

        // Sequencer still works after the aborted access
        add(1'b0, 16'h1234, 16'h0000);
        add(1'b1, 16'h0003, 16'hC0DE);
        add(1'b0, 16'h0003, 16'h0000);
        run_burst();

`ifdef SRAM_SEQ_WRITE_LOCK_EN
        // Locked write is suppressed and flagged; the following read completes
        wr_enable = 1'b0;
        add(1'b1, 16'h0001, 16'hBEEF);
        add(1'b0, 16'h0001, 16'h0000);
        run_burst();
        idle_check(3, "idle_locked");
        chk("wr_err_sticky", 32'(wr_err), 32'(1));
        wr_enable = 1'b1;
        rst_bar = 1'b0;
        @(negedge clk);
        rst_bar = 1'b1;
        err_exp = 1'b0;
        chk("wr_err_cleared", 32'(wr_err), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_seq.md
# sram_seq

Registered access sequencer for the 71V016SA 64K×16 asynchronous SRAM on the ASIC tester board. It converts single-word read/write requests from the tester logic into glitch-free active-low CS/OE/WE strobes, address and data-bus control. Its strobe outputs feed the SRAM_CTRL pin stage, and the tristate data buffer lives at board top level. Write protection enforces the rule that SRAM accepts writes only while input vectors are being loaded.

## Interface
Parameters:
- ADDR_W, 16, SRAM word address width
- DATA_W, 16, SRAM data width; BHE/BLE are tied low at board level, so only full words are accessed
- RD_WAIT, 2, cycles OE_BAR is held low before data is sampled; legal range 1..15
- WR_PULSE, 2, cycles WE_BAR is held low; legal range 1..15
- TURN_CYC, 1, idle cycles with all strobes high after each access; legal range 1..15

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, 100 MHz nominal
- RST_BAR  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  sequencer can accept a request
- REQ_WRITE  in  1  1 = write, 0 = read
- REQ_ADDR  in  ADDR_W  word address
- REQ_WDATA  in  DATA_W  write data
- RD_VALID  out  1  one-cycle pulse; RD_DATA is valid
- RD_DATA  out  DATA_W  captured read word
- SRAM_ADDR  out  ADDR_W  SRAM address pins
- SRAM_DQ_OUT  out  DATA_W  data driven to SRAM
- SRAM_DQ_OE  out  1  1 = top level drives DQ
- SRAM_DQ_IN  in  DATA_W  DQ pins sampled
- CS_BAR, OE_BAR, WE_BAR  out  1 each  SRAM strobes
- WR_ENABLE  in  1  present only with SRAM_SEQ_WRITE_LOCK_EN
- WR_ERR  out  1  present only with SRAM_SEQ_WRITE_LOCK_EN

## Operation
- State machine states:
  - IDLE: REQ_READY=1; a request is accepted when REQ_VALID and REQ_READY are both high at a rising edge. Address, data and direction are latched. Next state is SETUP.
  - SETUP (1 cycle): SRAM_ADDR driven and CS_BAR=0. For a write, SRAM_DQ_OE=1 and SRAM_DQ_OUT=wdata. Next state is RD_ACT or WR_ACT.
  - RD_ACT (RD_WAIT cycles): CS_BAR=0, OE_BAR=0. On the edge that ends this state, RD_DATA is loaded from SRAM_DQ_IN. Next state is TURN.
  - WR_ACT (WR_PULSE cycles): CS_BAR=0, WE_BAR=0, data driven. Next state is WR_HOLD.
  - WR_HOLD (1 cycle): WE_BAR=1, while CS_BAR, address and data are held. Next state is TURN.
  - TURN (TURN_CYC cycles): all strobes high and SRAM_DQ_OE=0. Next state is IDLE.
- OE_BAR=0 and SRAM_DQ_OE=1 are never asserted in the same cycle. OE_BAR and WE_BAR are never both low.
- All strobes, the address and SRAM_DQ_OE come directly from flops, with no combinational path to the pins.
- A request arriving outside IDLE is held off by REQ_READY=0. The requester must keep it stable.
- SRAM_ADDR keeps its last value in IDLE and TURN.

## Timing
- Reset values: CS_BAR=OE_BAR=WE_BAR=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, RD_DATA=0, RD_VALID=0, WR_ERR=0, REQ_READY=1, state=IDLE.
- Reset asserted mid-access forces all strobes high immediately (asynchronously). The access is dropped and no RD_VALID is produced.
- Read: RD_VALID pulses in the cycle RD_WAIT+2 after the accept edge, which is the first TURN cycle.
- Write: WE_BAR is low for exactly WR_PULSE cycles, starting 2 cycles after the accept edge.
- Back-to-back throughput:
  - read: one access every RD_WAIT+2+TURN_CYC cycles
  - write: one access every WR_PULSE+3+TURN_CYC cycles
- With defaults at 100 MHz: OE is low for 20 ns (≥ tAA of 10 ns) and WE is low for 20 ns (≥ tWP).

## Configuration
- SRAM_SEQ_WRITE_LOCK_EN defined: the WR_ENABLE and WR_ERR ports exist.
  - A write accepted while WR_ENABLE=0 runs its full state sequence, but WE_BAR stays 1 and SRAM_DQ_OE stays 0.
  - WR_ERR is set at the accept edge and is sticky until reset.
- SRAM_SEQ_WRITE_LOCK_EN undefined: the ports are absent and every write executes.

## Structure
- Shared package sram_pkg holds:
  - state encodings (IDLE, SETUP, RD_ACT, WR_ACT, WR_HOLD, TURN)
  - default timing constants
  - the 4-bit timer width
- One sub-module, sram_seq_timer: a 4-bit loadable down-counter with a done flag, used for the RD_ACT, WR_ACT and TURN durations.

## Test plan
- Reset then idle: all strobes are 1, REQ_READY=1, and SRAM_DQ_OE=0 for 10 cycles.
- Write 0xA5C3 to 0x1234 with defaults:
  - WE_BAR is low for exactly 2 cycles starting 2 cycles after accept.
  - SRAM_DQ_OE=1 during SETUP, WR_ACT and WR_HOLD, with address 0x1234 stable throughout.
- Read of 0x1234 with the SRAM model returning 0xA5C3: RD_VALID pulses once 4 cycles after accept, with RD_DATA=0xA5C3, and OE_BAR and SRAM_DQ_OE never overlap.
- Back-to-back read, write, read with REQ_VALID held high:
  - REQ_READY drops during each access.
  - Spacing between accepts is 5, then 6 cycles.
  - Strobes return high in every TURN cycle.
- RST_BAR pulled low during WR_ACT: WE_BAR and CS_BAR go to 1 without waiting for a clock edge. After release, the state is IDLE and no RD_VALID appears.
- With SRAM_SEQ_WRITE_LOCK_EN defined and WR_ENABLE=0: a write to 0x0001 gives WE_BAR constantly 1 and WR_ERR=1 held until reset. A following read still completes.
